// File: rtl/apb_master.sv
// APB3 initiator: command/response front end driving one transfer at a time,
// with a wait-state timeout so a stuck slave cannot hang the bus.
module apb_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e            state_q, state_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CW-1:0]     wait_q, wait_d;

  logic accept;
  logic timed_out;

  assign cmd_ready = (state_q == IDLE) && !preset;
  assign accept    = cmd_valid && cmd_ready;
  assign timed_out = (TIMEOUT != 0) && (wait_q == WAIT_LAST);

  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  // State and datapath registers; reset drops the bus mid-transfer.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      wait_q        <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      wait_q        <= wait_d;
    end
  end

  // Next state: SETUP always lasts one cycle; ACCESS ends on ready or timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || timed_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus and response outputs; everything holds unless a phase changes it.
  always_comb begin
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    wait_d        = wait_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          if (cmd_write) pwdata_d = cmd_wdata;
          wait_d    = '0;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
        end else if (timed_out) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: phases, wait states, slave error,
// timeout, reset mid-transfer and back-to-back ordering.
module tb_apb_master;

  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_write = 1'b0;
  logic [7:0] cmd_addr = '0;
  logic [7:0] cmd_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       rsp_timeout;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata = '0;
  logic       pready = 1'b0;
  logic       pslverr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer from IDLE. The slave answers after `waits` ACCESS cycles
  // (never, if waits is large). Latency counts edges after the accept edge.
  task automatic xfer(string tag, bit w, logic [7:0] a, logic [7:0] d,
                      int waits, logic [7:0] rd, bit se,
                      int exp_lat, int exp_acc, logic [7:0] exp_rd,
                      bit exp_err, bit exp_to);
    int lat;
    int acc;
    bit done;
    chk({tag, ":rdy"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    pready    = 1'b0;
    pslverr   = 1'b0;
    tick();
    cmd_valid = 1'b0;
    cmd_write = ~w;
    cmd_addr  = 8'hFF;
    cmd_wdata = 8'h5A;
    chk({tag, ":setup"}, {psel, penable}, 2'b10);
    lat  = 0;
    acc  = 0;
    done = 1'b0;
    while (!done && lat < 100) begin
      if (penable) begin
        acc++;
        chk({tag, ":paddr"}, paddr, a);
        chk({tag, ":pwrite"}, pwrite, w);
        if (w) chk({tag, ":pwdata"}, pwdata, d);
        if (acc > waits) begin
          pready  = 1'b1;
          prdata  = rd;
          pslverr = se;
        end else begin
          pready  = 1'b0;
          prdata  = 8'hEE;
          pslverr = 1'b1;
        end
      end
      tick();
      lat++;
      if (rsp_valid) done = 1'b1;
    end
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 8'h00;
    chk({tag, ":done"}, done, 1);
    chk({tag, ":lat"}, lat, exp_lat);
    chk({tag, ":acc"}, acc, exp_acc);
    chk({tag, ":rdata"}, rsp_rdata, exp_rd);
    chk({tag, ":err"}, rsp_err, exp_err);
    chk({tag, ":to"}, rsp_timeout, exp_to);
    chk({tag, ":busoff"}, {psel, penable}, 2'b00);
    chk({tag, ":rdy2"}, cmd_ready, 1);
    tick();
    chk({tag, ":pulse"}, rsp_valid, 0);
  endtask

  logic [7:0] mem [256];
  bit         cw [3] = '{1'b1, 1'b1, 1'b0};
  logic [7:0] ca [3] = '{8'h02, 8'h00, 8'h02};
  logic [7:0] cd [3] = '{8'h64, 8'h80, 8'h00};
  int         acc_cyc [3];

  initial begin
    int  idx;
    int  cyc;
    int  rsp_n;
    bit  took;
    logic [7:0] last_rd;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    tick();
    tick();
    chk("rst:bus", {psel, penable, pwrite}, 3'b000);
    chk("rst:rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("rst:paddr", paddr, 8'h00);
    chk("rst:pwdata", pwdata, 8'h00);
    chk("rst:rdata", rsp_rdata, 8'h00);
    chk("rst:rdy", cmd_ready, 0);
    preset = 1'b0;
    #1;
    chk("rst:rdy_rel", cmd_ready, 1);

    // Write, zero wait: phase-by-phase
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h02;
    cmd_wdata = 8'h64;
    pready    = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("w0:setup", {psel, penable}, 2'b10);
    chk("w0:rdy", cmd_ready, 0);
    chk("w0:paddr_s", paddr, 8'h02);
    chk("w0:pwdata_s", pwdata, 8'h64);
    tick();
    chk("w0:access", {psel, penable}, 2'b11);
    chk("w0:paddr_a", paddr, 8'h02);
    chk("w0:pwdata_a", pwdata, 8'h64);
    chk("w0:norsp", rsp_valid, 0);
    tick();
    pready = 1'b0;
    chk("w0:rsp", rsp_valid, 1);
    chk("w0:err", rsp_err, 0);
    chk("w0:rdata", rsp_rdata, 8'h00);
    chk("w0:idle", {psel, penable}, 2'b00);
    chk("w0:hold", paddr, 8'h02);
    tick();
    chk("w0:pulse", rsp_valid, 0);

    // Read with three wait states
    xfer("rd3", 1'b0, 8'h02, 8'h00, 3, 8'h64, 1'b0,
         5, 4, 8'h64, 1'b0, 1'b0);
    chk("rd3:pwdata_kept", pwdata, 8'h64);

    // Slave error on write, then a normal transfer
    xfer("serr", 1'b1, 8'h07, 8'hAA, 0, 8'h33, 1'b1,
         2, 1, 8'h00, 1'b1, 1'b0);
    xfer("after", 1'b0, 8'h07, 8'h00, 1, 8'h11, 1'b0,
         3, 2, 8'h11, 1'b0, 1'b0);
    chk("after:pwdata", pwdata, 8'hAA);

    // Timeout: slave never ready
    xfer("tmo", 1'b0, 8'h09, 8'h00, 1000, 8'h77, 1'b0,
         17, 16, 8'h00, 1'b1, 1'b1);

    // Reset during ACCESS of a read
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h05;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mrst:access", {psel, penable}, 2'b11);
    preset = 1'b1;
    pready = 1'b1;
    prdata = 8'h99;
    tick();
    chk("mrst:bus", {psel, penable, pwrite}, 3'b000);
    chk("mrst:rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("mrst:paddr", paddr, 8'h00);
    chk("mrst:rdata", rsp_rdata, 8'h00);
    preset = 1'b0;
    pready = 1'b0;
    prdata = 8'h00;
    tick();
    chk("mrst:nopulse", rsp_valid, 0);
    xfer("mrst_rd", 1'b0, 8'h02, 8'h00, 0, 8'h64, 1'b0,
         2, 1, 8'h64, 1'b0, 1'b0);

    // Back-to-back: cmd_valid held, memory-backed slave
    idx     = 0;
    cyc     = 0;
    rsp_n   = 0;
    last_rd = 8'h00;
    while (rsp_n < 3 && cyc < 60) begin
      if (idx < 3) begin
        cmd_valid = 1'b1;
        cmd_write = cw[idx];
        cmd_addr  = ca[idx];
        cmd_wdata = cd[idx];
      end else begin
        cmd_valid = 1'b0;
      end
      if (psel && penable) begin
        pready = 1'b1;
        prdata = mem[paddr];
        if (pwrite) mem[paddr] = pwdata;
      end else begin
        pready = 1'b0;
      end
      took = cmd_valid && cmd_ready;
      tick();
      cyc++;
      if (took) begin
        acc_cyc[idx] = cyc;
        chk("b2b:order", paddr, ca[idx]);
        idx++;
      end
      if (rsp_valid) begin
        rsp_n++;
        last_rd = rsp_rdata;
      end
    end
    cmd_valid = 1'b0;
    pready    = 1'b0;
    chk("b2b:count", rsp_n, 3);
    chk("b2b:gap1", acc_cyc[1] - acc_cyc[0], 3);
    chk("b2b:gap2", acc_cyc[2] - acc_cyc[1], 3);
    chk("b2b:rdata", last_rd, 8'h64);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
